// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch-flush squash and a saturating load-use stall counter.
module id_ex_hazard_reg #(
  parameter int W    = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ID_rs,
  input  logic [4:0]      ID_rt,
  input  logic [4:0]      ID_rd,
  input  logic [W-1:0]    ID_rd1,
  input  logic [W-1:0]    ID_rd2,
  input  logic [W-1:0]    ID_imm,
  input  logic [W-1:0]    ID_pc4,
  input  logic            ID_regwrite,
  input  logic            ID_memread,
  input  logic            ID_memwrite,
  input  logic            ID_memtoreg,
  input  logic            ID_regdst,
  input  logic            ID_alusrc,
  input  logic [2:0]      ID_aluop,
  input  logic            flush,
  output logic [4:0]      EX_rs,
  output logic [4:0]      EX_rt,
  output logic [4:0]      EX_rd,
  output logic [W-1:0]    EX_rd1,
  output logic [W-1:0]    EX_rd2,
  output logic [W-1:0]    EX_imm,
  output logic [W-1:0]    EX_pc4,
  output logic            EX_regwrite,
  output logic            EX_memread,
  output logic            EX_memwrite,
  output logic            EX_memtoreg,
  output logic            EX_regdst,
  output logic            EX_alusrc,
  output logic [2:0]      EX_aluop,
  output logic            pc_write,
  output logic            IF_ID_write,
  output logic [CNTW-1:0] stall_cnt
);

  typedef struct packed {
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [W-1:0] imm;
    logic [W-1:0] pc4;
    logic         regwrite;
    logic         memread;
    logic         memwrite;
    logic         memtoreg;
    logic         regdst;
    logic         alusrc;
    logic [2:0]   aluop;
  } idex_t;

  idex_t          id_w;
  idex_t          ex_q, ex_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic           haz;

  assign id_w = '{rs: ID_rs, rt: ID_rt, rd: ID_rd,
                  rd1: ID_rd1, rd2: ID_rd2, imm: ID_imm, pc4: ID_pc4,
                  regwrite: ID_regwrite, memread: ID_memread,
                  memwrite: ID_memwrite, memtoreg: ID_memtoreg,
                  regdst: ID_regdst, alusrc: ID_alusrc, aluop: ID_aluop};

  // A load in EX whose destination is read by ID; register 0 never counts.
  assign haz = ex_q.memread && (ex_q.rt != 5'd0) &&
               ((ex_q.rt == ID_rs) || (ex_q.rt == ID_rt));

  assign pc_write    = ~haz;
  assign IF_ID_write = ~haz;

  always_comb begin
    ex_d  = id_w;
    cnt_d = cnt_q;
    if (flush || haz) ex_d = '0;
    if (haz && !flush && (cnt_q != {CNTW{1'b1}}))
      cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign EX_rs       = ex_q.rs;
  assign EX_rt       = ex_q.rt;
  assign EX_rd       = ex_q.rd;
  assign EX_rd1      = ex_q.rd1;
  assign EX_rd2      = ex_q.rd2;
  assign EX_imm      = ex_q.imm;
  assign EX_pc4      = ex_q.pc4;
  assign EX_regwrite = ex_q.regwrite;
  assign EX_memread  = ex_q.memread;
  assign EX_memwrite = ex_q.memwrite;
  assign EX_memtoreg = ex_q.memtoreg;
  assign EX_regdst   = ex_q.regdst;
  assign EX_alusrc   = ex_q.alusrc;
  assign EX_aluop    = ex_q.aluop;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: reset, load-use stall, false-stall
// cases, flush priority, counter saturation (CNTW=4) and streaming capture.
module tb_id_ex_hazard_reg;

  localparam int W    = 32;
  localparam int CNTW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   ID_rs, ID_rt, ID_rd;
  logic [W-1:0] ID_rd1, ID_rd2, ID_imm, ID_pc4;
  logic         ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg, ID_regdst, ID_alusrc;
  logic [2:0]   ID_aluop;
  logic         flush;
  logic [4:0]   EX_rs, EX_rt, EX_rd;
  logic [W-1:0] EX_rd1, EX_rd2, EX_imm, EX_pc4;
  logic         EX_regwrite, EX_memread, EX_memwrite, EX_memtoreg, EX_regdst, EX_alusrc;
  logic [2:0]   EX_aluop;
  logic         pc_write, IF_ID_write;
  logic [CNTW-1:0] stall_cnt;

  int checks = 0;
  int passed = 0;

  id_ex_hazard_reg #(.W(W), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_rd1(ID_rd1), .ID_rd2(ID_rd2), .ID_imm(ID_imm), .ID_pc4(ID_pc4),
    .ID_regwrite(ID_regwrite), .ID_memread(ID_memread), .ID_memwrite(ID_memwrite),
    .ID_memtoreg(ID_memtoreg), .ID_regdst(ID_regdst), .ID_alusrc(ID_alusrc),
    .ID_aluop(ID_aluop), .flush(flush),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
    .EX_rd1(EX_rd1), .EX_rd2(EX_rd2), .EX_imm(EX_imm), .EX_pc4(EX_pc4),
    .EX_regwrite(EX_regwrite), .EX_memread(EX_memread), .EX_memwrite(EX_memwrite),
    .EX_memtoreg(EX_memtoreg), .EX_regdst(EX_regdst), .EX_alusrc(EX_alusrc),
    .EX_aluop(EX_aluop), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] id_pack();
    return 160'({ID_rs, ID_rt, ID_rd, ID_rd1, ID_rd2, ID_imm, ID_pc4,
                 ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg,
                 ID_regdst, ID_alusrc, ID_aluop});
  endfunction

  function automatic logic [159:0] ex_pack();
    return 160'({EX_rs, EX_rt, EX_rd, EX_rd1, EX_rd2, EX_imm, EX_pc4,
                 EX_regwrite, EX_memread, EX_memwrite, EX_memtoreg,
                 EX_regdst, EX_alusrc, EX_aluop});
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memtoreg/alusrc follow memread (load-like), regdst is set for R-type.
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic mr, input logic rw, input logic [2:0] op,
                        input logic [31:0] seed);
    ID_rs = rs; ID_rt = rt; ID_rd = rd;
    ID_rd1 = seed; ID_rd2 = ~seed; ID_imm = seed ^ 32'h5A5A_A5A5; ID_pc4 = seed + 32'd4;
    ID_memread = mr; ID_regwrite = rw; ID_memwrite = 1'b0;
    ID_memtoreg = mr; ID_regdst = ~mr; ID_alusrc = mr; ID_aluop = op;
    #1;
  endtask

  logic [159:0] exp_v;
  int           exp_cnt;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    set_id(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 3'($urandom), $urandom);
    ID_memwrite = 1'b1;
    repeat (2) tick();
    chk("reset_ex",       ex_pack(),   160'd0);
    chk("reset_cnt",      160'(stall_cnt), 160'd0);
    chk("reset_pcw",      160'(pc_write), 160'd1);
    chk("reset_ifidw",    160'(IF_ID_write), 160'd1);

    // Release away from the edge; the next edge captures.
    rst_n = 1'b1;
    set_id(5'd3, 5'd4, 5'd5, 1'b0, 1'b1, 3'd2, 32'h1234_5678);
    exp_v = id_pack();
    tick();
    chk("first_capture", ex_pack(), exp_v);

    // Load-use: lw $8 in EX, add reads $8 in ID.
    set_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 3'd0, 32'h0000_1000);
    tick();
    set_id(5'd8, 5'd9, 5'd10, 1'b0, 1'b1, 3'd2, 32'hCAFE_0001);
    exp_v = id_pack();
    chk("lu_pcw",   160'(pc_write), 160'd0);
    chk("lu_ifidw", 160'(IF_ID_write), 160'd0);
    tick();
    chk("lu_bubble_ex",  ex_pack(), 160'd0);
    chk("lu_cnt1",       160'(stall_cnt), 160'd1);
    chk("lu_pcw_after",  160'(pc_write), 160'd1);
    tick();
    chk("lu_add_capt",   ex_pack(), exp_v);
    chk("lu_add_rs",     160'(EX_rs), 160'd8);

    // lw with rt=0 against ID rs=0: no stall.
    set_id(5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0, 32'h0000_2000);
    tick();
    set_id(5'd0, 5'd6, 5'd7, 1'b0, 1'b1, 3'd3, 32'h0BAD_F00D);
    exp_v = id_pack();
    chk("r0_pcw", 160'(pc_write), 160'd1);
    tick();
    chk("r0_capt", ex_pack(), exp_v);

    // Non-load with EX_rt=5 against ID_rt=5: no stall.
    set_id(5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 3'd2, 32'h0000_3000);
    tick();
    set_id(5'd2, 5'd5, 5'd11, 1'b0, 1'b1, 3'd2, 32'h0000_3333);
    exp_v = id_pack();
    chk("nomr_pcw", 160'(pc_write), 160'd1);
    tick();
    chk("nomr_capt", ex_pack(), exp_v);
    chk("nomr_cnt",  160'(stall_cnt), 160'd1);

    // Flush with a simultaneous load-use: bubble, counter unchanged.
    set_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 3'd0, 32'h0000_4000);
    tick();
    set_id(5'd8, 5'd12, 5'd13, 1'b0, 1'b1, 3'd2, 32'h0000_4444);
    flush = 1'b1;
    #1;
    chk("flush_pcw", 160'(pc_write), 160'd0);
    tick();
    flush = 1'b0;
    chk("flush_bubble", ex_pack(), 160'd0);
    chk("flush_cnt",    160'(stall_cnt), 160'd1);

    // Flush alone squashes an ordinary instruction.
    set_id(5'd14, 5'd15, 5'd16, 1'b0, 1'b1, 3'd4, 32'h0000_5555);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_plain", ex_pack(), 160'd0);

    // 20 load-use pairs; counter is at 1 and must stop at 15.
    for (int i = 0; i < 20; i++) begin
      set_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 3'd0, 32'h0000_6000 + 32'(i));
      tick();
      set_id((i % 2 == 0) ? 5'd8 : 5'd3, (i % 2 == 0) ? 5'd9 : 5'd8, 5'd17,
             1'b0, 1'b1, 3'd2, 32'h0000_7000 + 32'(i));
      chk("sat_pcw", 160'(pc_write), 160'd0);
      tick();
      exp_cnt = (i + 2 > 15) ? 15 : i + 2;
      chk("sat_cnt", 160'(stall_cnt), 160'(exp_cnt));
    end
    tick();
    chk("sat_hold", 160'(stall_cnt), 160'd15);

    // Back-to-back independent instructions.
    for (int i = 0; i < 10; i++) begin
      set_id(5'(i + 1), 5'(i + 2), 5'(i + 3), 1'b0, 1'b1, 3'(i), $urandom);
      ID_memwrite = i[0];
      exp_v = id_pack();
      chk("b2b_pcw", 160'(pc_write), 160'd1);
      tick();
      chk("b2b_capt", ex_pack(), exp_v);
    end

    // Reset mid-stall clears everything at once.
    set_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 3'd0, 32'h0000_8000);
    tick();
    set_id(5'd8, 5'd9, 5'd10, 1'b0, 1'b1, 3'd2, 32'h0000_8888);
    chk("mid_pcw", 160'(pc_write), 160'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ex",  ex_pack(), 160'd0);
    chk("mid_rst_cnt", 160'(stall_cnt), 160'd0);
    chk("mid_rst_pcw", 160'(pc_write), 160'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
